// File: rtl/vi_pipe_pkg.sv
// Shared pipeline widths plus the latency helper used by the exe/reg bypass logic.
// Pure package: no state, no timing.
package vi_pipe_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LAT_W      = 3;

  // A zero latency field still occupies the long unit for one cycle.
  function automatic logic [LAT_W-1:0] eff_latency(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? LAT_W'(1) : lat;
  endfunction

endpackage

// File: rtl/bypass_mux.sv
// Operand forward select: x0 -> exe -> long return -> writeback -> register file.
// Purely combinational, zero latency, no backpressure.
module bypass_mux
  import vi_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]       i_reg_data,
  input  logic                  i_exe_we,
  input  logic [REG_ADDR_W-1:0] i_exe_addr,
  input  logic [XLEN-1:0]       i_exe_data,
  input  logic                  i_long_vld,
  input  logic [REG_ADDR_W-1:0] i_long_addr,
  input  logic [XLEN-1:0]       i_long_data,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_data
);

  always_comb begin
    o_data = i_reg_data;
    if (i_addr == '0)
      o_data = '0;
    else if (i_exe_we && (i_exe_addr == i_addr))
      o_data = i_exe_data;
    else if (i_long_vld && (i_long_addr == i_addr))
      o_data = i_long_data;
    else if (i_wb_we && (i_wb_addr == i_addr))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/exe_reg_bypass.sv
// Reg->exe operand bypass with long-op scoreboard; fwd is combinational, stall is same-cycle.
// Stall holds the register stage on RAW/WAW against in-flight long ops or a busy long unit.
module exe_reg_bypass
  import vi_pipe_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reg_issue_valid,
  input  logic [REG_ADDR_W-1:0] reg_read_addr_a,
  input  logic [REG_ADDR_W-1:0] reg_read_addr_b,
  input  logic [XLEN-1:0]       reg_int_data_a,
  input  logic [XLEN-1:0]       reg_int_data_b,
  input  logic                  reg_int_write_enable,
  input  logic [REG_ADDR_W-1:0] reg_write_addr,
  input  logic                  reg_is_long,
  input  logic [LAT_W-1:0]      reg_long_latency,
  input  logic                  exe_int_write_enable,
  input  logic [REG_ADDR_W-1:0] exe_write_addr,
  input  logic [XLEN-1:0]       exe_result,
  input  logic                  long_valid,
  input  logic [REG_ADDR_W-1:0] long_write_addr,
  input  logic [XLEN-1:0]       long_data,
  input  logic                  wb_int_write_enable,
  input  logic [REG_ADDR_W-1:0] wb_write_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       fwd_int_data_a,
  output logic [XLEN-1:0]       fwd_int_data_b,
  output logic                  stall
);

  logic [NUM_REGS-1:0] r_busy;
  logic [LAT_W-1:0]    r_long_cnt;

  logic [NUM_REGS-1:0] w_busy_nxt;
  logic w_raw_a, w_raw_b, w_waw, w_struct;
  logic w_accept, w_long_issue, w_busy_set;

  // A long result returning this cycle is forwarded, so it resolves its own hazard.
  assign w_raw_a  = (reg_read_addr_a != '0) && r_busy[reg_read_addr_a] &&
                    !(long_valid && (long_write_addr == reg_read_addr_a));
  assign w_raw_b  = (reg_read_addr_b != '0) && r_busy[reg_read_addr_b] &&
                    !(long_valid && (long_write_addr == reg_read_addr_b));
  assign w_waw    = reg_int_write_enable && r_busy[reg_write_addr] &&
                    !(long_valid && (long_write_addr == reg_write_addr));
  assign w_struct = reg_is_long && (r_long_cnt != '0);

  assign stall = reg_issue_valid && !reset && (w_raw_a || w_raw_b || w_waw || w_struct);

  assign w_accept     = reg_issue_valid && !stall;
  assign w_long_issue = w_accept && reg_is_long;
  assign w_busy_set   = w_long_issue && reg_int_write_enable && (reg_write_addr != '0);

  // Set is applied after clear so a same-address collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (long_valid)
      w_busy_nxt[long_write_addr] = 1'b0;
    if (w_busy_set)
      w_busy_nxt[reg_write_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy     <= '0;
      r_long_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_long_issue)
        r_long_cnt <= eff_latency(reg_long_latency);
      else if (r_long_cnt != '0)
        r_long_cnt <= r_long_cnt - LAT_W'(1);
    end
  end

  bypass_mux u_mux_a (
    .i_addr      (reg_read_addr_a),
    .i_reg_data  (reg_int_data_a),
    .i_exe_we    (exe_int_write_enable),
    .i_exe_addr  (exe_write_addr),
    .i_exe_data  (exe_result),
    .i_long_vld  (long_valid),
    .i_long_addr (long_write_addr),
    .i_long_data (long_data),
    .i_wb_we     (wb_int_write_enable),
    .i_wb_addr   (wb_write_addr),
    .i_wb_data   (wb_data),
    .o_data      (fwd_int_data_a)
  );

  bypass_mux u_mux_b (
    .i_addr      (reg_read_addr_b),
    .i_reg_data  (reg_int_data_b),
    .i_exe_we    (exe_int_write_enable),
    .i_exe_addr  (exe_write_addr),
    .i_exe_data  (exe_result),
    .i_long_vld  (long_valid),
    .i_long_addr (long_write_addr),
    .i_long_data (long_data),
    .i_wb_we     (wb_int_write_enable),
    .i_wb_addr   (wb_write_addr),
    .i_wb_data   (wb_data),
    .o_data      (fwd_int_data_b)
  );

endmodule

// File: tb/tb_exe_reg_bypass.sv
// Bench for exe_reg_bypass: forwarding vector table plus hazard sequences,
// expected outputs queued at drive time and compared at the falling edge.
module tb_exe_reg_bypass;
  import vi_pipe_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  reg_issue_valid;
  logic [REG_ADDR_W-1:0] reg_read_addr_a, reg_read_addr_b;
  logic [XLEN-1:0]       reg_int_data_a, reg_int_data_b;
  logic                  reg_int_write_enable;
  logic [REG_ADDR_W-1:0] reg_write_addr;
  logic                  reg_is_long;
  logic [LAT_W-1:0]      reg_long_latency;
  logic                  exe_int_write_enable;
  logic [REG_ADDR_W-1:0] exe_write_addr;
  logic [XLEN-1:0]       exe_result;
  logic                  long_valid;
  logic [REG_ADDR_W-1:0] long_write_addr;
  logic [XLEN-1:0]       long_data;
  logic                  wb_int_write_enable;
  logic [REG_ADDR_W-1:0] wb_write_addr;
  logic [XLEN-1:0]       wb_data;
  logic [XLEN-1:0]       fwd_int_data_a, fwd_int_data_b;
  logic                  stall;

  always #5 clock = ~clock;

  exe_reg_bypass dut (
    .clock(clock), .reset(reset), .reg_issue_valid(reg_issue_valid),
    .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
    .reg_int_data_a(reg_int_data_a), .reg_int_data_b(reg_int_data_b),
    .reg_int_write_enable(reg_int_write_enable), .reg_write_addr(reg_write_addr),
    .reg_is_long(reg_is_long), .reg_long_latency(reg_long_latency),
    .exe_int_write_enable(exe_int_write_enable), .exe_write_addr(exe_write_addr),
    .exe_result(exe_result), .long_valid(long_valid), .long_write_addr(long_write_addr),
    .long_data(long_data), .wb_int_write_enable(wb_int_write_enable),
    .wb_write_addr(wb_write_addr), .wb_data(wb_data),
    .fwd_int_data_a(fwd_int_data_a), .fwd_int_data_b(fwd_int_data_b), .stall(stall)
  );

  typedef struct packed {
    logic [4:0]  addr_a;  logic [4:0]  addr_b;
    logic [63:0] rd_a;    logic [63:0] rd_b;
    logic        exe_we;  logic [4:0]  exe_addr;  logic [63:0] exe_res;
    logic        lv;      logic [4:0]  laddr;     logic [63:0] ldata;
    logic        wb_we;   logic [4:0]  wb_addr;   logic [63:0] wdata;
    logic [63:0] exp_a;   logic [63:0] exp_b;
  } vec_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        st;
    logic        chk_b;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic clr();
    reg_issue_valid = 1'b0; reg_read_addr_a = '0; reg_read_addr_b = '0;
    reg_int_data_a = '0; reg_int_data_b = '0; reg_int_write_enable = 1'b0;
    reg_write_addr = '0; reg_is_long = 1'b0; reg_long_latency = '0;
    exe_int_write_enable = 1'b0; exe_write_addr = '0; exe_result = '0;
    long_valid = 1'b0; long_write_addr = '0; long_data = '0;
    wb_int_write_enable = 1'b0; wb_write_addr = '0; wb_data = '0;
  endtask

  task automatic issue(input logic lng, input logic we, input logic [4:0] wa,
                       input logic [2:0] lat, input logic [4:0] ra);
    reg_issue_valid = 1'b1; reg_is_long = lng; reg_int_write_enable = we;
    reg_write_addr = wa; reg_long_latency = lat; reg_read_addr_a = ra;
  endtask

  // Queue the expectation for the inputs just driven, then sample mid-cycle.
  task automatic step(input logic st, input logic [63:0] ea, input logic cb,
                      input logic [63:0] eb, input string name);
    exp_t e;
    e.a = ea; e.b = eb; e.st = st; e.chk_b = cb; e.name = name;
    exp_q.push_back(e);
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++;
    if (stall !== e.st) begin
      n_fail++;
      $display("FAIL %s stall: got %0b expected %0b", e.name, stall, e.st);
    end
    n_checks++;
    if (fwd_int_data_a !== e.a) begin
      n_fail++;
      $display("FAIL %s fwd_a: got %h expected %h", e.name, fwd_int_data_a, e.a);
    end
    if (e.chk_b) begin
      n_checks++;
      if (fwd_int_data_b !== e.b) begin
        n_fail++;
        $display("FAIL %s fwd_b: got %h expected %h", e.name, fwd_int_data_b, e.b);
      end
    end
    @(posedge clock);
    #1;
    clr();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{5'd5, 5'd6, 64'h11, 64'h22, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0,
                1'b0, 5'd0, 64'h0, 64'hAA, 64'h22};
    vecs[1] = '{5'd0, 5'd7, 64'h55, 64'h77, 1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2,
                1'b1, 5'd7, 64'h3, 64'h0, 64'h1};
    vecs[2] = '{5'd7, 5'd7, 64'h70, 64'h71, 1'b0, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2,
                1'b1, 5'd7, 64'h3, 64'h2, 64'h2};
    vecs[3] = '{5'd3, 5'd4, 64'h30, 64'h44, 1'b1, 5'd8, 64'h1, 1'b1, 5'd9, 64'h2,
                1'b1, 5'd3, 64'h3, 64'h3, 64'h44};
    vecs[4] = '{5'd8, 5'd0, 64'h80, 64'h81, 1'b0, 5'd8, 64'hE, 1'b0, 5'd8, 64'hF,
                1'b0, 5'd8, 64'hD, 64'h80, 64'h0};
    vecs[5] = '{5'd9, 5'd9, 64'h99, 64'h98, 1'b1, 5'd1, 64'hE, 1'b0, 5'd9, 64'hF,
                1'b0, 5'd9, 64'hD, 64'h99, 64'h98};
    vecs[6] = '{5'd31, 5'd30, 64'h1, 64'h2, 1'b1, 5'd31, 64'hDEADBEEF_01234567, 1'b1,
                5'd30, 64'hCAFEF00D_89ABCDEF, 1'b1, 5'd31, 64'h5, 64'hDEADBEEF_01234567,
                64'hCAFEF00D_89ABCDEF};

    clr();
    reset = 1'b1;
    #1;
    // Reset cycles: stall suppressed even for a long issue, forwarding still live.
    issue(1'b1, 1'b1, 5'd2, 3'd3, 5'd1);
    exe_int_write_enable = 1'b1; exe_write_addr = 5'd1; exe_result = 64'h5A;
    step(1'b0, 64'h5A, 1'b0, 64'h0, "reset0");
    issue(1'b1, 1'b1, 5'd2, 3'd3, 5'd1);
    reg_int_data_a = 64'h1234;
    step(1'b0, 64'h1234, 1'b0, 64'h0, "reset1");
    reset = 1'b0;

    // Combinational forwarding table (no long op in flight).
    for (int i = 0; i < 7; i++) begin
      reg_issue_valid = 1'b1;
      reg_read_addr_a = vecs[i].addr_a; reg_read_addr_b = vecs[i].addr_b;
      reg_int_data_a = vecs[i].rd_a; reg_int_data_b = vecs[i].rd_b;
      exe_int_write_enable = vecs[i].exe_we; exe_write_addr = vecs[i].exe_addr;
      exe_result = vecs[i].exe_res;
      long_valid = vecs[i].lv; long_write_addr = vecs[i].laddr; long_data = vecs[i].ldata;
      wb_int_write_enable = vecs[i].wb_we; wb_write_addr = vecs[i].wb_addr;
      wb_data = vecs[i].wdata;
      step(1'b0, vecs[i].exp_a, 1'b1, vecs[i].exp_b, $sformatf("vec%0d", i));
    end

    // RAW against a long op to x9, latency 4.
    issue(1'b1, 1'b1, 5'd9, 3'd4, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "raw_issue");
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd9); reg_int_data_a = 64'h9;
      step(1'b1, 64'h9, 1'b0, 64'h0, $sformatf("raw_wait%0d", i));
    end
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd9); reg_int_data_a = 64'h9;
    long_valid = 1'b1; long_write_addr = 5'd9; long_data = 64'h1234_5678;
    step(1'b0, 64'h1234_5678, 1'b0, 64'h0, "raw_return");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd9); reg_int_data_a = 64'h5;
    step(1'b0, 64'h5, 1'b0, 64'h0, "raw_cleared");

    // Structural: second long issue waits for long_cnt to drain.
    issue(1'b1, 1'b1, 5'd10, 3'd3, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "struct_first");
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 5'd11, 3'd3, 5'd0);
      step(1'b1, 64'h0, 1'b0, 64'h0, $sformatf("struct_wait%0d", i));
    end
    issue(1'b1, 1'b1, 5'd11, 3'd3, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "struct_accept");
    issue(1'b0, 1'b1, 5'd11, 3'd0, 5'd0);
    step(1'b1, 64'h0, 1'b0, 64'h0, "waw_stall");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd10);
    step(1'b1, 64'h0, 1'b0, 64'h0, "raw_x10");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd10);
    long_valid = 1'b1; long_write_addr = 5'd10; long_data = 64'hA;
    step(1'b0, 64'hA, 1'b0, 64'h0, "x10_return");
    issue(1'b0, 1'b1, 5'd11, 3'd0, 5'd0);
    long_valid = 1'b1; long_write_addr = 5'd11; long_data = 64'hB;
    step(1'b0, 64'h0, 1'b0, 64'h0, "waw_release");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd10); reg_read_addr_b = 5'd11;
    reg_int_data_a = 64'h10; reg_int_data_b = 64'h11;
    step(1'b0, 64'h10, 1'b1, 64'h11, "both_clear");

    // Set wins over clear on a same-address collision.
    issue(1'b1, 1'b1, 5'd4, 3'd1, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "coll_first");
    step(1'b0, 64'h0, 1'b0, 64'h0, "coll_gap");
    issue(1'b1, 1'b1, 5'd4, 3'd1, 5'd0);
    long_valid = 1'b1; long_write_addr = 5'd4; long_data = 64'h4;
    step(1'b0, 64'h0, 1'b0, 64'h0, "coll_issue");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd4);
    step(1'b1, 64'h0, 1'b0, 64'h0, "coll_busy");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd4);
    long_valid = 1'b1; long_write_addr = 5'd4; long_data = 64'h44;
    step(1'b0, 64'h44, 1'b0, 64'h0, "coll_return");

    // Latency 0 occupies the long unit for one cycle.
    issue(1'b1, 1'b0, 5'd0, 3'd0, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "lat0_issue");
    issue(1'b1, 1'b0, 5'd0, 3'd0, 5'd0);
    step(1'b1, 64'h0, 1'b0, 64'h0, "lat0_busy");
    issue(1'b1, 1'b0, 5'd0, 3'd0, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "lat0_free");

    // Reset mid-flight discards the x9 op and the long counter.
    issue(1'b1, 1'b1, 5'd9, 3'd3, 5'd0);
    step(1'b1, 64'h0, 1'b0, 64'h0, "rst_cnt_busy");
    step(1'b0, 64'h0, 1'b0, 64'h0, "rst_gap");
    issue(1'b1, 1'b1, 5'd9, 3'd3, 5'd0);
    step(1'b0, 64'h0, 1'b0, 64'h0, "rst_issue");
    reg_read_addr_a = 5'd9; reg_int_data_a = 64'h9;
    step(1'b0, 64'h9, 1'b0, 64'h0, "rst_idle_valid0");
    reset = 1'b1;
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd9); reg_int_data_a = 64'h9;
    step(1'b0, 64'h9, 1'b0, 64'h0, "rst_assert");
    reset = 1'b0;
    issue(1'b1, 1'b0, 5'd0, 3'd2, 5'd9);
    long_valid = 1'b1; long_write_addr = 5'd9; long_data = 64'h77;
    step(1'b0, 64'h77, 1'b0, 64'h0, "rst_after");
    issue(1'b0, 1'b0, 5'd0, 3'd0, 5'd9); reg_int_data_a = 64'h19;
    step(1'b0, 64'h19, 1'b0, 64'h0, "rst_x9_free");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
